// File: rtl/risc_control_fsm.sv
// risc_control_fsm: multi-cycle control unit for a 16-bit RISC datapath.
// Sequences fetch, decode, execute, memory and write-back phases from the
// instruction opcode and drives the datapath mux selects and write enables.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (forces IDLE)
//   opcode     instruction register bits [15:12]
//   zero       ALU zero flag, used by BEQ/BNE
//   mem_ready  memory access completes this cycle
//   ALU_srcA   ALU operand A select (00 PC, 01 regA)
//   ALU_srcB   ALU operand B select (000 regB, 001 sext imm, 010 branch off,
//              011 zext imm, 110 constant 2)
//   ALU_op     ALU function (000 ADD, 001 SUB, 010 AND, 011 OR)
//   PC_src     PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   reg_dst, memtoreg, shift                          datapath mux selects
//   PC_write, IR_write, IorD, mem_read, mem_write, reg_write  enables
//   halted     processor stopped
//   illegal    one-cycle pulse on an undefined opcode in DECODE
//
// Outputs are combinational decodes of the current state (plus mem_ready,
// zero and opcode where noted) so that async reset clears them immediately.

module risc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_srcA,
  output logic [2:0] ALU_srcB,
  output logic [2:0] ALU_op,
  output logic [1:0] PC_src,
  output logic       reg_dst,
  output logic       memtoreg,
  output logic       shift,
  output logic       PC_write,
  output logic       IR_write,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       halted,
  output logic       illegal
);

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SRCA_W  = 2;
  localparam int unsigned SRCB_W  = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned PCSRC_W = 2;

  // Opcode map
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(4'hF);

  // Mux select encodings
  localparam logic [SRCA_W-1:0]  SRCA_PC    = SRCA_W'(2'b00);
  localparam logic [SRCA_W-1:0]  SRCA_REGA  = SRCA_W'(2'b01);
  localparam logic [SRCB_W-1:0]  SRCB_REGB  = SRCB_W'(3'b000);
  localparam logic [SRCB_W-1:0]  SRCB_SEXT  = SRCB_W'(3'b001);
  localparam logic [SRCB_W-1:0]  SRCB_BOFF  = SRCB_W'(3'b010);
  localparam logic [SRCB_W-1:0]  SRCB_ZEXT  = SRCB_W'(3'b011);
  localparam logic [SRCB_W-1:0]  SRCB_TWO   = SRCB_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB    = ALUOP_W'(3'b001);
  localparam logic [PCSRC_W-1:0] PCSRC_ALU  = PCSRC_W'(2'b00);
  localparam logic [PCSRC_W-1:0] PCSRC_OUT  = PCSRC_W'(2'b01);
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP = PCSRC_W'(2'b10);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_SH  = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_ALU_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t state;
  state_t next_state;

  // Opcode class decodes, only consumed in DECODE and execute/write-back states
  logic op_is_rtype;
  logic op_is_shift;
  logic op_is_illegal;
  logic branch_taken;

  always_comb begin
    op_is_rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
    op_is_shift   = (opcode == OP_SLL) || (opcode == OP_SRL);
    op_is_illegal = (opcode == OPC_W'(4'hC)) || (opcode == OPC_W'(4'hD)) ||
                    (opcode == OPC_W'(4'hE));
    branch_taken  = ((opcode == OP_BEQ) &&  zero) ||
                    ((opcode == OP_BNE) && !zero);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: next_state = S_EXEC_R;
          OP_ADDI:                       next_state = S_EXEC_I;
          OP_SLL, OP_SRL:                next_state = S_EXEC_SH;
          OP_LW, OP_SW:                  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                next_state = S_BRANCH;
          OP_JMP:                        next_state = S_JUMP;
          OP_HALT:                       next_state = S_HALT;
          default:                       next_state = S_FETCH;
        endcase
      end
      S_EXEC_R:   next_state = S_ALU_WB;
      S_EXEC_I:   next_state = S_ALU_WB;
      S_EXEC_SH:  next_state = S_ALU_WB;
      S_ALU_WB:   next_state = S_FETCH;
      S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output decode; everything not driven in a state stays 0
  always_comb begin
    ALU_srcA  = SRCA_PC;
    ALU_srcB  = SRCB_REGB;
    ALU_op    = ALU_ADD;
    PC_src    = PCSRC_ALU;
    reg_dst   = 1'b0;
    memtoreg  = 1'b0;
    shift     = 1'b0;
    PC_write  = 1'b0;
    IR_write  = 1'b0;
    IorD      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        // PC + 2 computed every cycle; committed only when memory answers
        mem_read = 1'b1;
        ALU_srcA = SRCA_PC;
        ALU_srcB = SRCB_TWO;
        ALU_op   = ALU_ADD;
        PC_src   = PCSRC_ALU;
        IR_write = mem_ready;
        PC_write = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        ALU_srcA = SRCA_PC;
        ALU_srcB = SRCB_BOFF;
        ALU_op   = ALU_ADD;
        illegal  = op_is_illegal;
      end
      S_EXEC_R: begin
        ALU_srcA = SRCA_REGA;
        ALU_srcB = SRCB_REGB;
        ALU_op   = opcode[ALUOP_W-1:0];
      end
      S_EXEC_I: begin
        ALU_srcA = SRCA_REGA;
        ALU_srcB = SRCB_SEXT;
        ALU_op   = ALU_ADD;
      end
      S_EXEC_SH: begin
        shift    = 1'b1;
        ALU_srcA = SRCA_REGA;
        ALU_srcB = SRCB_ZEXT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b0;
        reg_dst   = op_is_rtype || op_is_shift;
        shift     = op_is_shift;
      end
      S_MEM_ADDR: begin
        ALU_srcA = SRCA_REGA;
        ALU_srcB = SRCB_SEXT;
        ALU_op   = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
        reg_dst   = 1'b0;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      S_BRANCH: begin
        // Compare by subtraction; ALUOut already holds the target
        ALU_srcA = SRCA_REGA;
        ALU_srcB = SRCB_REGB;
        ALU_op   = ALU_SUB;
        PC_src   = PCSRC_OUT;
        PC_write = branch_taken;
      end
      S_JUMP: begin
        PC_write = 1'b1;
        PC_src   = PCSRC_JUMP;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Directed, table-driven bench for risc_control_fsm. Each table row is one
// clock cycle: inputs are driven on the falling edge and outputs compared
// 1 time unit later. Reset and halt corner cases follow as hand sequences.

module tb_risc_control_fsm;

  typedef struct packed {
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       memtoreg;
    logic       shift;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] op;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] ALU_srcA;
  logic [2:0] ALU_srcB;
  logic [2:0] ALU_op;
  logic [1:0] PC_src;
  logic reg_dst, memtoreg, shift, PC_write, IR_write, IorD;
  logic mem_read, mem_write, reg_write, halted, illegal;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  out_t got;

  risc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .ALU_op(ALU_op), .PC_src(PC_src),
    .reg_dst(reg_dst), .memtoreg(memtoreg), .shift(shift), .PC_write(PC_write),
    .IR_write(IR_write), .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {ALU_srcA, ALU_srcB, ALU_op, PC_src, reg_dst, memtoreg, shift,
                PC_write, IR_write, IorD, mem_read, mem_write, reg_write,
                halted, illegal};

  // Expected output patterns per state
  function automatic out_t e_none();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t e_fetch(input logic rdy);
    out_t o = '0;
    o.srcb = 3'b110; o.mem_read = 1'b1; o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction
  function automatic out_t e_decode(input logic ill);
    out_t o = '0;
    o.srcb = 3'b010; o.illegal = ill;
    return o;
  endfunction
  function automatic out_t e_exec_r(input logic [2:0] f);
    out_t o = '0;
    o.srca = 2'b01; o.alu_op = f;
    return o;
  endfunction
  function automatic out_t e_exec_i();
    out_t o = '0;
    o.srca = 2'b01; o.srcb = 3'b001;
    return o;
  endfunction
  function automatic out_t e_exec_sh();
    out_t o = '0;
    o.srca = 2'b01; o.srcb = 3'b011; o.shift = 1'b1;
    return o;
  endfunction
  function automatic out_t e_alu_wb(input logic dst, input logic sh);
    out_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = dst; o.shift = sh;
    return o;
  endfunction
  function automatic out_t e_mem_rd();
    out_t o = '0;
    o.mem_read = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_mem_wb();
    out_t o = '0;
    o.reg_write = 1'b1; o.memtoreg = 1'b1;
    return o;
  endfunction
  function automatic out_t e_mem_wr();
    out_t o = '0;
    o.mem_write = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_branch(input logic taken);
    out_t o = '0;
    o.srca = 2'b01; o.alu_op = 3'b001; o.pc_src = 2'b01; o.pc_write = taken;
    return o;
  endfunction
  function automatic out_t e_jump();
    out_t o = '0;
    o.pc_write = 1'b1; o.pc_src = 2'b10;
    return o;
  endfunction
  function automatic out_t e_halt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic z,
                     input logic rdy, input out_t e);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] op, input logic z,
                       input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic check(input string name, input int idx, input out_t e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, e);
    end
  endtask

  initial begin
    // Reset, then release: IDLE for one cycle
    add(1, 4'h0, 0, 1, e_none());
    add(0, 4'h0, 0, 1, e_none());
    // ADD
    add(0, 4'h0, 0, 1, e_fetch(1));
    add(0, 4'h0, 0, 1, e_decode(0));
    add(0, 4'h0, 0, 1, e_exec_r(3'b000));
    add(0, 4'h0, 0, 1, e_alu_wb(1, 0));
    // SUB with one fetch wait; opcode HALT during FETCH must be ignored
    add(0, 4'hF, 0, 0, e_fetch(0));
    add(0, 4'h1, 0, 1, e_fetch(1));
    add(0, 4'h1, 0, 1, e_decode(0));
    add(0, 4'h1, 0, 1, e_exec_r(3'b001));
    add(0, 4'h1, 0, 1, e_alu_wb(1, 0));
    // AND, OR
    add(0, 4'h2, 0, 1, e_fetch(1));
    add(0, 4'h2, 0, 1, e_decode(0));
    add(0, 4'h2, 0, 1, e_exec_r(3'b010));
    add(0, 4'h2, 0, 1, e_alu_wb(1, 0));
    add(0, 4'h3, 0, 1, e_fetch(1));
    add(0, 4'h3, 0, 1, e_decode(0));
    add(0, 4'h3, 0, 1, e_exec_r(3'b011));
    add(0, 4'h3, 0, 1, e_alu_wb(1, 0));
    // ADDI
    add(0, 4'h4, 0, 1, e_fetch(1));
    add(0, 4'h4, 0, 1, e_decode(0));
    add(0, 4'h4, 0, 1, e_exec_i());
    add(0, 4'h4, 0, 1, e_alu_wb(0, 0));
    // SLL, SRL
    add(0, 4'h5, 0, 1, e_fetch(1));
    add(0, 4'h5, 0, 1, e_decode(0));
    add(0, 4'h5, 0, 1, e_exec_sh());
    add(0, 4'h5, 0, 1, e_alu_wb(1, 1));
    add(0, 4'h6, 0, 1, e_fetch(1));
    add(0, 4'h6, 0, 1, e_decode(0));
    add(0, 4'h6, 0, 1, e_exec_sh());
    add(0, 4'h6, 0, 1, e_alu_wb(1, 1));
    // LW with two read wait cycles: 7 cycles total
    add(0, 4'h7, 0, 1, e_fetch(1));
    add(0, 4'h7, 0, 1, e_decode(0));
    add(0, 4'h7, 0, 1, e_exec_i());
    add(0, 4'h7, 0, 0, e_mem_rd());
    add(0, 4'h7, 0, 0, e_mem_rd());
    add(0, 4'h7, 0, 1, e_mem_rd());
    add(0, 4'h7, 0, 1, e_mem_wb());
    // SW with one write wait
    add(0, 4'h8, 0, 1, e_fetch(1));
    add(0, 4'h8, 0, 1, e_decode(0));
    add(0, 4'h8, 0, 1, e_exec_i());
    add(0, 4'h8, 0, 0, e_mem_wr());
    add(0, 4'h8, 0, 1, e_mem_wr());
    // BEQ/BNE, both zero values
    add(0, 4'h9, 1, 1, e_fetch(1));
    add(0, 4'h9, 1, 1, e_decode(0));
    add(0, 4'h9, 1, 1, e_branch(1));
    add(0, 4'hA, 1, 1, e_fetch(1));
    add(0, 4'hA, 1, 1, e_decode(0));
    add(0, 4'hA, 1, 1, e_branch(0));
    add(0, 4'hA, 0, 1, e_fetch(1));
    add(0, 4'hA, 0, 1, e_decode(0));
    add(0, 4'hA, 0, 1, e_branch(1));
    add(0, 4'h9, 0, 1, e_fetch(1));
    add(0, 4'h9, 0, 1, e_decode(0));
    add(0, 4'h9, 0, 1, e_branch(0));
    // JMP
    add(0, 4'hB, 0, 1, e_fetch(1));
    add(0, 4'hB, 0, 1, e_decode(0));
    add(0, 4'hB, 0, 1, e_jump());
    // Illegal opcodes: one-cycle pulse, straight back to FETCH
    add(0, 4'hD, 0, 1, e_fetch(1));
    add(0, 4'hD, 0, 1, e_decode(1));
    add(0, 4'hC, 0, 1, e_fetch(1));
    add(0, 4'hC, 0, 1, e_decode(1));
    add(0, 4'hE, 0, 1, e_fetch(1));
    add(0, 4'hE, 0, 1, e_decode(1));
    // HALT
    add(0, 4'hF, 0, 1, e_fetch(1));
    add(0, 4'hF, 0, 1, e_decode(0));
    add(0, 4'h0, 0, 1, e_halt());

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy);
      check("vec", i, vecs[i].exp);
    end

    // HALT holds regardless of inputs
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      check("halt_hold", i, e_halt());
    end

    // Reset pulse out of HALT: IDLE then FETCH
    drive(1'b1, 4'hF, 0, 1);
    check("halt_rst", 0, e_none());
    drive(1'b0, 4'hF, 0, 1);
    check("halt_rst", 1, e_none());
    drive(1'b0, 4'h0, 0, 0);
    check("halt_rst", 2, e_fetch(0));

    // Async reset in the middle of a FETCH wait
    drive(1'b0, 4'h0, 0, 0);
    check("fetch_wait", 0, e_fetch(0));
    #2 rst = 1'b1;
    #1 check("fetch_rst_async", 0, e_none());
    mem_ready = 1'b1;
    #1 check("fetch_rst_rdy", 0, e_none());
    drive(1'b1, 4'h0, 0, 1);
    check("fetch_rst_hold", 0, e_none());
    drive(1'b0, 4'h0, 0, 1);
    check("fetch_rst_idle", 0, e_none());

    // Async reset in the middle of a MEM_RD wait, then a clean ADD
    drive(1'b0, 4'h7, 0, 1);
    check("lw_rst", 0, e_fetch(1));
    drive(1'b0, 4'h7, 0, 1);
    check("lw_rst", 1, e_decode(0));
    drive(1'b0, 4'h7, 0, 1);
    check("lw_rst", 2, e_exec_i());
    drive(1'b0, 4'h7, 0, 0);
    check("lw_rst", 3, e_mem_rd());
    #2 rst = 1'b1;
    #1 check("lw_rst_async", 0, e_none());
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 4, e_none());
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 5, e_fetch(1));
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 6, e_decode(0));
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 7, e_exec_r(3'b000));
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 8, e_alu_wb(1, 0));
    drive(1'b0, 4'h0, 0, 1);
    check("lw_rst", 9, e_fetch(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_control_fsm.md
RISC_CONTROL_FSM -- requirements
Module: risc_control_fsm

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  instruction register bits [15:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- ALU_srcA  out  2  00 = PC, 01 = regA
- ALU_srcB  out  3  000 = regB, 001 = sign-ext imm, 010 = shifted branch offset, 011 = zero-ext imm, 110 = constant 2
- ALU_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
- PC_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- reg_dst, memtoreg, shift  out  1  mux selects
- PC_write, IR_write, IorD, mem_read, mem_write, reg_write  out  1  enables
- halted  out  1  processor stopped
- illegal  out  1  one-cycle pulse on an undefined opcode
REQ-002 SHALL use one clock domain (clk); rst SHALL be asynchronous and active-high.

Function
REQ-003 Opcode map SHALL be: 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 ADDI, 0x5 SLL, 0x6 SRL, 0x7 LW, 0x8 SW, 0x9 BEQ, 0xA BNE, 0xB JMP, 0xF HALT. 0xC–0xE SHALL be illegal.
REQ-004 States SHALL be: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_SH, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT.
REQ-005 IDLE SHALL assert no outputs and SHALL go to FETCH on the next edge.
REQ-006 FETCH SHALL assert mem_read, IorD = 0, ALU_srcA = 00, ALU_srcB = 110 and ALU_op = ADD. It SHALL hold while mem_ready = 0. In the mem_ready = 1 cycle it SHALL also assert IR_write and PC_write with PC_src = 00, then go to DECODE.
REQ-007 DECODE SHALL drive ALU_srcA = 00, ALU_srcB = 010 and ALU_op = ADD (branch target into ALUOut). It SHALL go to:
- EXEC_R for 0x0–0x3
- EXEC_I for 0x4
- EXEC_SH for 0x5–0x6
- MEM_ADDR for 0x7–0x8
- BRANCH for 0x9–0xA
- JUMP for 0xB
- HALT for 0xF
- FETCH for an illegal opcode, with illegal pulsed for that one cycle
REQ-008 EXEC_R SHALL drive ALU_srcA = 01, ALU_srcB = 000 and ALU_op = opcode[2:0], then go to ALU_WB.
REQ-009 EXEC_I SHALL drive ALU_srcA = 01, ALU_srcB = 001 and ALU_op = ADD, then go to ALU_WB.
REQ-010 EXEC_SH SHALL assert shift with ALU_srcA = 01 and ALU_srcB = 011, then go to ALU_WB.
REQ-011 ALU_WB SHALL assert reg_write with memtoreg = 0. reg_dst SHALL be 1 for R-type/shift and 0 for ADDI. shift SHALL stay asserted when the opcode is a shift. Next state SHALL be FETCH.
REQ-012 MEM_ADDR SHALL drive ALU_srcA = 01, ALU_srcB = 001 and ALU_op = ADD, then go to MEM_RD (LW) or MEM_WR (SW).
REQ-013 MEM_RD SHALL assert mem_read with IorD = 1, hold while mem_ready = 0, then go to MEM_WB.
REQ-014 MEM_WB SHALL assert reg_write with memtoreg = 1 and reg_dst = 0, then go to FETCH.
REQ-015 MEM_WR SHALL assert mem_write with IorD = 1, hold while mem_ready = 0, then go to FETCH.
REQ-016 BRANCH SHALL drive ALU_srcA = 01, ALU_srcB = 000, ALU_op = SUB and PC_src = 01. It SHALL assert PC_write only when (BEQ and zero = 1) or (BNE and zero = 0). Next state SHALL be FETCH.
REQ-017 JUMP SHALL assert PC_write with PC_src = 10, then go to FETCH.
REQ-018 HALT SHALL assert only halted and SHALL remain in HALT until rst.
REQ-019 Outputs SHALL be combinational decodes of the state, except:
- PC_write and IR_write in FETCH, which also depend on mem_ready
- PC_write in BRANCH, which also depends on zero
- illegal, which depends on opcode in DECODE
REQ-020 Outputs with no assignment in a state SHALL be 0 (selects 00/000). No output SHALL ever be X or Z.
REQ-021 Cycle counts with mem_ready held at 1 SHALL be: R-type/ADDI/shift 4, LW 5, SW 4, BEQ/BNE 3, JMP 3. Each wait cycle adds one.
REQ-022 The opcode input SHALL be sampled only in DECODE and the execute/write-back states. It SHALL be ignored in FETCH, IDLE and HALT.

Reset
REQ-023 Asserting rst SHALL force IDLE immediately, from any state and even mid-wait; all outputs SHALL be 0 and no write enable SHALL pulse.
REQ-024 After rst deasserts, the first rising edge SHALL enter IDLE→FETCH; the first instruction fetch SHALL begin one cycle after reset release.

Verification
REQ-025 ADD (0x0), mem_ready = 1 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write = 1 with reg_dst = 1 in cycle 4; ALU_op = 000 in EXEC_R.
REQ-026 LW (0x7), mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_read = 1 with IorD = 1 for 3 cycles; reg_write = 1 with memtoreg = 1 in MEM_WB.
REQ-027 BEQ with zero = 1 → PC_write = 1 with PC_src = 01 in BRANCH. BNE with zero = 1 → PC_write = 0. Both return to FETCH.
REQ-028 Opcode 0xD → illegal = 1 for exactly one cycle in DECODE; no reg_write/mem_write; next state FETCH.
REQ-029 HALT (0xF) → halted = 1 held for 20+ cycles regardless of opcode/mem_ready; rst pulse → IDLE then FETCH.
REQ-030 rst asserted mid-FETCH wait (mem_ready = 0) → all outputs 0 within the same cycle; no IR_write/PC_write pulse.
